// File: rtl/culsans_cdc_pkg.sv
// Shared helpers for the culsans gray-pointer async FIFO channels.
// Gray helpers work on CDC_MAXW bits; callers zero-extend and cast back to their pointer width.
package culsans_cdc_pkg;

    localparam int unsigned CDC_MAXW       = 16;

    localparam int unsigned AXI_ID_WIDTH   = 5;
    localparam int unsigned AXI_USER_WIDTH = 1;
    localparam int unsigned AXI_ADDR_WIDTH = 64;
    localparam int unsigned AXI_DATA_WIDTH = 64;

    // id + addr + len/size/burst/lock/cache/prot/qos/region (+ atop on AW) + user
    localparam int unsigned AW_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4
                                       + 6 + AXI_USER_WIDTH;
    localparam int unsigned AR_WIDTH = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4
                                       + AXI_USER_WIDTH;
    localparam int unsigned W_WIDTH  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1 + AXI_USER_WIDTH;
    localparam int unsigned B_WIDTH  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
    localparam int unsigned R_WIDTH  = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2 + 1 + AXI_USER_WIDTH;

    function automatic logic [CDC_MAXW-1:0] bin2gray(input logic [CDC_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [CDC_MAXW-1:0] gray2bin(input logic [CDC_MAXW-1:0] gray);
        logic [CDC_MAXW-1:0] bin;
        bin[CDC_MAXW-1] = gray[CDC_MAXW-1];
        for (int i = CDC_MAXW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/culsans_cdc_sync.sv
// Vector of Stages-deep flop synchronizers; input goes straight into the first flop.
// Latency Stages edges, no backpressure; async active-high reset to 0.
module culsans_cdc_sync #(
    parameter int unsigned Width  = 1,
    parameter int unsigned Stages = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Stages-1:0][Width-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[Stages-2:0], i_d};
        end
    end

    assign o_q = r_sync[Stages-1];

endmodule

// File: rtl/culsans_cdc_dst_channel.sv
// Read end of a gray-pointer async FIFO: syncs wptr, pops into a registered valid/ready stage.
// wptr change -> valid after SyncStages+1 edges; output holds while valid && !ready.
module culsans_cdc_dst_channel
    import culsans_cdc_pkg::*;
#(
    parameter int unsigned Width      = 8,
    parameter int unsigned LogDepth   = 1,
    parameter int unsigned SyncStages = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [LogDepth:0]                async_wptr_i,
    input  logic [(2**LogDepth)*Width-1:0]   async_data_i,
    output logic [LogDepth:0]                async_rptr_o,
    output logic [Width-1:0]                 dst_data_o,
    output logic                             dst_valid_o,
    input  logic                             dst_ready_i,
    output logic [LogDepth:0]                fill_o
);

    localparam int unsigned PtrW  = LogDepth + 1;
    localparam int unsigned Depth = 2 ** LogDepth;

    logic [Width-1:0] w_entries [Depth];
    logic [PtrW-1:0]  w_wptr_sync;
    logic [PtrW-1:0]  w_wptr_bin;
    logic [PtrW-1:0]  w_rptr_bin_nxt;
    logic             w_empty;
    logic             w_load;

    logic [PtrW-1:0]  r_rptr_bin;
    logic [PtrW-1:0]  r_rptr_gray;
    logic [PtrW-1:0]  r_fill;
    logic [Width-1:0] r_data;
    logic             r_valid;

    for (genvar k = 0; k < Depth; k++) begin : g_entry
        assign w_entries[k] = async_data_i[k*Width +: Width];
    end

    culsans_cdc_sync #(
        .Width  (PtrW),
        .Stages (SyncStages)
    ) u_wptr_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (async_wptr_i),
        .o_q   (w_wptr_sync)
    );

    // Full-width gray compare keeps "empty" distinct from "full" (MSB differs when full).
    assign w_empty        = (w_wptr_sync == r_rptr_gray);
    assign w_load         = !w_empty && (!r_valid || dst_ready_i);
    assign w_wptr_bin     = PtrW'(gray2bin(CDC_MAXW'(w_wptr_sync)));
    assign w_rptr_bin_nxt = w_load ? r_rptr_bin + PtrW'(1) : r_rptr_bin;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_fill      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_rptr_bin  <= w_rptr_bin_nxt;
            r_rptr_gray <= PtrW'(bin2gray(CDC_MAXW'(w_rptr_bin_nxt)));
            r_fill      <= w_wptr_bin - w_rptr_bin_nxt;
            if (w_load) begin
                r_data  <= w_entries[r_rptr_bin[LogDepth-1:0]];
                r_valid <= 1'b1;
            end else if (dst_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign async_rptr_o = r_rptr_gray;
    assign dst_data_o   = r_data;
    assign dst_valid_o  = r_valid;
    assign fill_o       = r_fill;

endmodule

// File: tb/tb_culsans_cdc_dst_channel.sv
// Directed bench for the destination CDC channel plus a randomised deeper instance with scoreboard.
module tb_culsans_cdc_dst_channel;

    logic        clk;
    logic        rst;

    logic [1:0]  wptr;
    logic [15:0] data;
    logic        ready;
    logic [1:0]  rptr;
    logic [7:0]  dout;
    logic        valid;
    logic [1:0]  fill;

    logic [2:0]  wptr2;
    logic [31:0] data2;
    logic        ready2;
    logic [2:0]  rptr2;
    logic [7:0]  dout2;
    logic        valid2;
    logic [2:0]  fill2;

    int checks = 0;
    int errors = 0;

    culsans_cdc_dst_channel #(.Width(8), .LogDepth(1), .SyncStages(2)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .async_wptr_i (wptr),
        .async_data_i (data),
        .async_rptr_o (rptr),
        .dst_data_o   (dout),
        .dst_valid_o  (valid),
        .dst_ready_i  (ready),
        .fill_o       (fill)
    );

    culsans_cdc_dst_channel #(.Width(8), .LogDepth(2), .SyncStages(3)) u_dut2 (
        .clk_i        (clk),
        .rst_i        (rst),
        .async_wptr_i (wptr2),
        .async_data_i (data2),
        .async_rptr_o (rptr2),
        .dst_data_o   (dout2),
        .dst_valid_o  (valid2),
        .dst_ready_i  (ready2),
        .fill_o       (fill2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] w);
        rst   = 1'b1;
        wptr  = w;
        wptr2 = 3'b000;
        #1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] b2g3(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] g2b3(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = g[2] ^ g[1] ^ g[0];
        return b;
    endfunction

    // Protocol monitors: rptr moves by at most one bit, payload holds under backpressure.
    logic       p_ok = 1'b0;
    logic [1:0] p_rptr;
    logic [2:0] p_rptr2;
    logic       p_v, p_r, p_v2, p_r2;
    logic [7:0] p_d, p_d2;

    always @(negedge clk) begin
        if (rst) begin
            p_ok = 1'b0;
        end else begin
            if (p_ok) begin
                chk("rptr_1bit", 32'($countones(rptr ^ p_rptr) <= 1), 32'd1);
                chk("rptr2_1bit", 32'($countones(rptr2 ^ p_rptr2) <= 1), 32'd1);
                if (p_v && !p_r) begin
                    chk("hold_vld", valid, 1);
                    chk("hold_dat", dout, p_d);
                end
                if (p_v2 && !p_r2) begin
                    chk("hold2_vld", valid2, 1);
                    chk("hold2_dat", dout2, p_d2);
                end
            end
            p_ok    = 1'b1;
            p_rptr  = rptr;
            p_rptr2 = rptr2;
            p_v     = valid;
            p_r     = ready;
            p_d     = dout;
            p_v2    = valid2;
            p_r2    = ready2;
            p_d2    = dout2;
        end
    end

    logic [1:0] gseq [4];
    logic [7:0] q [$];
    logic [2:0] wbin2;
    logic [2:0] occ;
    logic [7:0] b;
    logic [31:0] exp_d;

    initial begin
        gseq = '{2'b00, 2'b01, 2'b11, 2'b10};
        rst = 1'b0; wptr = 2'b01; data = 16'hBBA5; ready = 1'b0;
        wptr2 = '0; data2 = '0; ready2 = 1'b0;

        // Reset holds everything at zero even with a nonzero remote wptr
        #1 rst = 1'b1;
        #2;
        chk("rst_vld", valid, 0);
        chk("rst_dat", dout, 0);
        chk("rst_rptr", rptr, 0);
        chk("rst_fill", fill, 0);
        step(); step();
        chk("rst_hold_vld", valid, 0);
        chk("rst_hold_rptr", rptr, 0);
        rst = 1'b0;
        step(); chk("lat_e1_vld", valid, 0);
        step(); chk("lat_e2_vld", valid, 0);
        step();
        chk("lat_e3_vld", valid, 1);
        chk("lat_e3_dat", dout, 8'hA5);
        chk("lat_e3_rptr", rptr, 2'b01);

        // Single entry with ready held high
        ready = 1'b1;
        do_reset(2'b00);
        wptr = 2'b01;
        step(); chk("single_e1_vld", valid, 0);
        step(); chk("single_e2_vld", valid, 0);
        step();
        chk("single_vld", valid, 1);
        chk("single_dat", dout, 8'hA5);
        chk("single_rptr", rptr, 2'b01);
        chk("single_fill", fill, 0);
        step();
        chk("single_drop_vld", valid, 0);
        chk("single_drop_rptr", rptr, 2'b01);

        // Two entries (FIFO full) under backpressure, then drain back to back
        ready = 1'b0;
        do_reset(2'b00);
        wptr = 2'b01;
        step();
        wptr = 2'b11;
        step();
        step();
        chk("bp_vld", valid, 1);
        chk("bp_dat", dout, 8'hA5);
        chk("bp_rptr", rptr, 2'b01);
        chk("bp_fill0", fill, 0);
        step();
        chk("bp_fill1", fill, 1);
        step(); step();
        chk("bp_hold_dat", dout, 8'hA5);
        chk("bp_hold_rptr", rptr, 2'b01);
        chk("bp_hold_fill", fill, 1);
        ready = 1'b1;
        step();
        chk("bp_2nd_vld", valid, 1);
        chk("bp_2nd_dat", dout, 8'hBB);
        chk("bp_2nd_rptr", rptr, 2'b11);
        chk("bp_2nd_fill", fill, 0);
        step();
        chk("bp_end_vld", valid, 0);
        chk("bp_end_rptr", rptr, 2'b11);

        // Pointer wrap: eight single pushes walk the gray sequence twice
        ready = 1'b1;
        do_reset(2'b00);
        for (int k = 0; k < 8; k++) begin
            data[(k % 2) * 8 +: 8] = 8'h30 + 8'(k);
            wptr = gseq[(k + 1) % 4];
            for (int c = 0; c < 8 && !valid; c++) step();
            chk("wrap_vld", valid, 1);
            chk("wrap_dat", dout, 8'h30 + 8'(k));
            chk("wrap_rptr", rptr, gseq[(k + 1) % 4]);
            step();
            chk("wrap_empty_vld", valid, 0);
            chk("wrap_fill", fill, 0);
        end
        chk("wrap_rptr_home", rptr, 2'b00);
        step(); step(); step();
        chk("wrap_no_spurious", valid, 0);

        // Asynchronous reset while a beat is held
        ready = 1'b0;
        do_reset(2'b00);
        wptr = 2'b01;
        step(); step(); step();
        chk("arst_pre_vld", valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_vld", valid, 0);
        chk("arst_rptr", rptr, 0);
        chk("arst_dat", dout, 0);
        chk("arst_fill", fill, 0);
        wptr = 2'b00;
        step();
        rst = 1'b0;
        step();

        // Random traffic on the deeper instance against an in-order scoreboard
        wbin2 = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ready2 = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (valid2 && ready2) begin
                exp_d = (q.size() > 0) ? 32'(q.pop_front()) : 32'hDEAD;
                chk("rnd_dat", dout2, exp_d);
            end
            occ = wbin2 - g2b3(rptr2);
            if (cyc < 300 && occ < 3'd4 && $urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                data2[wbin2[1:0] * 8 +: 8] = b;
                q.push_back(b);
                wbin2 = wbin2 + 3'd1;
                wptr2 = b2g3(wbin2);
            end
            step();
        end
        chk("rnd_drained", q.size(), 0);
        chk("rnd_end_vld", valid2, 0);
        chk("rnd_end_fill", fill2, 0);
        chk("rnd_end_rptr", rptr2, wptr2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
